// File: rtl/ft6336_i2c_target.sv
// FT6336G touch-controller register emulation on the panel side of the CTP I2C bus.
// Answers DEV_ADDR with a read-only register map built from a per-START snapshot of the touch inputs.
`timescale 1ns/1ps
module ft6336_i2c_target #(
  parameter logic [6:0] DEV_ADDR        = 7'h38,
  parameter logic [7:0] CHIP_ID         = 8'h64,
  parameter logic [7:0] VENDOR_ID       = 8'h11,
  parameter int         SDA_HOLD_CYCLES = 15
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_drive_low,
  output logic        int_n,
  input  logic        touch_down,
  input  logic [11:0] touch_x,
  input  logic [11:0] touch_y,
  output logic        busy,
  output logic        addr_hit
);

  localparam int HOLD_W = (SDA_HOLD_CYCLES > 2) ? $clog2(SDA_HOLD_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_PTR, WR_ACK, WR_DATA, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [7:0]        tx;
  logic [7:0]        ptr;
  logic              rw;
  logic              snap_down;
  logic [11:0]       snap_x;
  logic [11:0]       snap_y;
  logic              hold_act;
  logic [HOLD_W-1:0] hold_cnt;
  logic              drive_want;

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  function automatic logic [7:0] reg_byte(input logic [7:0] a, input logic d,
                                          input logic [11:0] x, input logic [11:0] y);
    case (a)
      8'h02:   reg_byte = {7'b0, d};
      8'h03:   reg_byte = {(d ? 2'b10 : 2'b01), 2'b00, x[11:8]};
      8'h04:   reg_byte = x[7:0];
      8'h05:   reg_byte = {4'h0, y[11:8]};
      8'h06:   reg_byte = y[7:0];
      8'hA3:   reg_byte = CHIP_ID;
      8'hA8:   reg_byte = VENDOR_ID;
      default: reg_byte = 8'h00;
    endcase
  endfunction

  // Stage p0/p1: two-flop synchronizer; stage p2: history flop for edge detection
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
    end else begin
      {scl_p0, scl_p1, scl_p2} <= {scl_in, scl_p0, scl_p1};
      {sda_p0, sda_p1, sda_p2} <= {sda_in, sda_p0, sda_p1};
    end
  end

  // A bus event needs SCL steady high; coincident SCL/SDA edges are treated as a data bit.
  wire scl_rise  = scl_p1 & ~scl_p2;
  wire scl_fall  = ~scl_p1 & scl_p2;
  wire scl_hi    = scl_p1 & scl_p2;
  wire start_det = ~sda_p1 & sda_p2 & scl_hi;
  wire stop_det  = sda_p1 & ~sda_p2 & scl_hi;

  always_comb begin
    drive_want = 1'b0;
    case (state)
      ADDR_ACK, WR_ACK: drive_want = 1'b1;
      RD_DATA:          drive_want = ~tx[7];
      default:          drive_want = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      shreg         <= 8'h00;
      tx            <= 8'h00;
      ptr           <= 8'h00;
      rw            <= 1'b0;
      snap_down     <= 1'b0;
      snap_x        <= 12'h000;
      snap_y        <= 12'h000;
      hold_act      <= 1'b0;
      hold_cnt      <= '0;
      sda_drive_low <= 1'b0;
      busy          <= 1'b0;
      addr_hit      <= 1'b0;
      int_n         <= 1'b1;
    end else begin
      int_n    <= ~touch_down;
      addr_hit <= 1'b0;

      // SDA only moves a fixed hold time after SCL falls; a rise before expiry cancels the change.
      if (scl_fall) begin
        hold_act <= 1'b1;
        hold_cnt <= HOLD_W'(SDA_HOLD_CYCLES - 1);
      end else if (hold_act) begin
        if (scl_p1) begin
          hold_act <= 1'b0;
        end else if (hold_cnt == '0) begin
          hold_act      <= 1'b0;
          sda_drive_low <= drive_want;
        end else begin
          hold_cnt <= hold_cnt - 1'b1;
        end
      end

      if (stop_det) begin
        state         <= IDLE;
        busy          <= 1'b0;
        sda_drive_low <= 1'b0;
        hold_act      <= 1'b0;
      end else if (start_det) begin
        state         <= ADDR;
        bit_cnt       <= 3'd0;
        busy          <= 1'b1;
        sda_drive_low <= 1'b0;
        hold_act      <= 1'b0;
        snap_down     <= touch_down;
        snap_x        <= touch_x;
        snap_y        <= touch_y;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            shreg   <= {shreg[6:0], sda_p1};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw <= sda_p1;
              if (shreg[6:0] == DEV_ADDR) begin
                state    <= ADDR_ACK;
                addr_hit <= 1'b1;
              end else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            bit_cnt <= 3'd0;
            if (rw) begin
              tx    <= reg_byte(ptr, snap_down, snap_x, snap_y);
              state <= RD_DATA;
            end else begin
              state <= WR_PTR;
            end
          end
          WR_PTR, WR_DATA: begin
            shreg   <= {shreg[6:0], sda_p1};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= (state == WR_PTR) ? {shreg[6:0], sda_p1} : ptr + 8'd1;
              state <= WR_ACK;
            end
          end
          WR_ACK: begin
            bit_cnt <= 3'd0;
            state   <= WR_DATA;
          end
          RD_DATA: begin
            tx      <= {tx[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RD_ACK;
          end
          RD_ACK: begin
            ptr     <= ptr + 8'd1;
            bit_cnt <= 3'd0;
            if (!sda_p1) begin
              tx    <= reg_byte(ptr + 8'd1, snap_down, snap_x, snap_y);
              state <= RD_DATA;
            end else begin
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
